fir_decim_buffer: RTL and testbench

FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

---
 rtl/fir_decim_buffer.sv | 133 +++++++++++++
 tb/tb_fir_decim_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer
//   Decimates the FIR output stream by DECIM. Each group of DECIM samples is
//   summed, rounded to nearest (ties up) and divided by DECIM. Each result is
//   pushed into a small FIFO that feeds a ready/valid consumer. The input
//   side never stalls: if the FIFO is full and nothing pops, the result is
//   dropped and the sticky overflow flag is set.
//
// Parameters
//   DECIM       decimation ratio, power of two, 2..16
//   DEPTH       FIFO depth in entries, power of two, 2..16
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   in_data     16-bit unsigned filter output sample
//   in_valid    in_data is valid this cycle
//   out_data    sample at the FIFO head, 0 while the FIFO is empty
//   out_valid   FIFO non-empty
//   out_ready   consumer takes out_data on this edge
//   fifo_level  FIFO occupancy, 0..DEPTH
//   overflow    sticky, a decimated result was dropped
//   ovf_clear   clears overflow on the next edge (a simultaneous drop wins)
module fir_decim_buffer #(
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  fifo_level,
    output logic        overflow,
    input  logic        ovf_clear
);

    localparam int LG = $clog2(DECIM);
    localparam int AW = 16 + LG;
    localparam int PW = $clog2(DEPTH);

    localparam logic [LG-1:0] PH_LAST  = LG'(DECIM - 1);
    localparam logic [AW:0]   HALF     = (AW + 1)'(DECIM / 2);
    localparam logic [4:0]    LVL_FULL = 5'(DEPTH);

    logic [LG-1:0] phase;
    logic [AW-1:0] acc;
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [AW-1:0] sum_next;
    logic [AW:0]   rounded;
    logic [15:0]   result;
    logic          complete;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    always_comb begin
        sum_next = '0;
        rounded  = '0;
        result   = '0;

        // Phase 0 starts a fresh block, so the previous sum is not carried in.
        if (phase == '0) begin
            sum_next = {{LG{1'b0}}, in_data};
        end else begin
            sum_next = acc + {{LG{1'b0}}, in_data};
        end

        // One spare bit so that adding the rounding constant cannot wrap.
        rounded = {1'b0, sum_next} + HALF;
        result  = 16'(rounded >> LG);
    end

    assign complete   = in_valid && (phase == PH_LAST);
    assign fifo_empty = (fifo_level == 5'd0);
    assign fifo_full  = (fifo_level == LVL_FULL);
    assign pop        = out_ready && !fifo_empty;
    // A pop on the same edge frees the head slot, so a full FIFO still accepts.
    assign push_ok    = complete && (!fifo_full || pop);
    assign drop       = complete && fifo_full && !pop;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 16'd0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            acc        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 5'd0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= phase + 1'b1;
                acc   <= sum_next;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 5'd1;
                2'b01:   fifo_level <= fifo_level - 5'd1;
                default: fifo_level <= fifo_level;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; out_data masks it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= result;
        end
    end

endmodule

// File: tb/tb_fir_decim_buffer.sv
module tb_fir_decim_buffer;

    localparam int DECIM = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        ovf_clear = 1'b0;

    fir_decim_buffer #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a list of samples in the current block and a queue
    // standing in for the FIFO.
    int sq[$];
    int mq[$];
    bit m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit r, input bit c);
        bit full;
        bit pop;
        bit dropped;
        int sum;
        full    = (mq.size() == DEPTH);
        pop     = r && (mq.size() > 0);
        dropped = 1'b0;
        if (pop) void'(mq.pop_front());
        if (v) begin
            sq.push_back(d);
            if (sq.size() == DECIM) begin
                sum = 0;
                foreach (sq[i]) sum += sq[i];
                sq.delete();
                if (full && !pop) dropped = 1'b1;
                else mq.push_back((sum + DECIM / 2) / DECIM);
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    int'(out_valid),  (mq.size() > 0) ? 1 : 0);
        chk({tag, ".data"},     int'(out_data),   (mq.size() > 0) ? mq[0] : 0);
        chk({tag, ".level"},    int'(fifo_level), mq.size());
        chk({tag, ".overflow"}, int'(overflow),   int'(m_ovf));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at
    // the same point after the following edge.
    task automatic step(input bit v, input int d, input bit r, input bit c, input string tag);
        in_valid  = v;
        in_data   = d[15:0];
        out_ready = r;
        ovf_clear = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit v;
        int d;
        bit r;
        bit c;
        bit ev;
        int ed;
        int el;
    } vec_t;

    vec_t tbl[12];
    int   exp_list[4];

    initial begin
        tbl[0]  = '{1'b1, 3,     1'b1, 1'b0, 1'b0, 0,     0};
        tbl[1]  = '{1'b1, 4,     1'b1, 1'b0, 1'b1, 4,     1};
        tbl[2]  = '{1'b0, 0,     1'b1, 1'b0, 1'b0, 0,     0};
        tbl[3]  = '{1'b1, 65535, 1'b1, 1'b0, 1'b0, 0,     0};
        tbl[4]  = '{1'b1, 65535, 1'b1, 1'b0, 1'b1, 65535, 1};
        tbl[5]  = '{1'b1, 0,     1'b1, 1'b0, 1'b0, 0,     0};
        tbl[6]  = '{1'b1, 1,     1'b1, 1'b0, 1'b1, 1,     1};
        tbl[7]  = '{1'b1, 10,    1'b1, 1'b0, 1'b0, 0,     0};
        tbl[8]  = '{1'b0, 99,    1'b1, 1'b0, 1'b0, 0,     0};
        tbl[9]  = '{1'b0, 77,    1'b1, 1'b0, 1'b0, 0,     0};
        tbl[10] = '{1'b1, 20,    1'b1, 1'b0, 1'b1, 15,    1};
        tbl[11] = '{1'b0, 0,     1'b1, 1'b0, 1'b0, 0,     0};

        // Reset state
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;

        // Directed table: rounding, full-scale sum, in_valid gaps
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, "tbl");
            chk($sformatf("tbl[%0d].valid", i), int'(out_valid),  int'(tbl[i].ev));
            chk($sformatf("tbl[%0d].data", i),  int'(out_data),   tbl[i].ed);
            chk($sformatf("tbl[%0d].level", i), int'(fifo_level), tbl[i].el);
        end

        // Backpressure: 10 pairs with out_ready low, results 100*i+1
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i * 100,     1'b0, 1'b0, "bp");
            step(1'b1, i * 100 + 1, 1'b0, 1'b0, "bp");
        end
        chk("bp.level_sat", int'(fifo_level), 4);
        chk("bp.overflow",  int'(overflow),   1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp.drain[%0d]", i), int'(out_data), i * 100 + 1);
            step(1'b0, 0, 1'b1, 1'b0, "bp_drain");
        end
        chk("bp.empty_valid", int'(out_valid), 0);
        chk("bp.empty_data",  int'(out_data),  0);
        step(1'b0, 0, 1'b1, 1'b0, "bp_underflow");
        chk("bp.no_underflow", int'(fifo_level), 0);
        step(1'b0, 0, 1'b0, 1'b1, "bp_clr");
        chk("bp.ovf_cleared", int'(overflow), 0);

        // Full FIFO with a pop on the same edge as a push
        for (int j = 1; j <= 4; j++) begin
            step(1'b1, j * 10, 1'b0, 1'b0, "full");
            step(1'b1, j * 10, 1'b0, 1'b0, "full");
        end
        chk("full.level", int'(fifo_level), 4);
        step(1'b1, 50, 1'b0, 1'b0, "pp");
        step(1'b1, 50, 1'b1, 1'b0, "pp");
        chk("pp.level",    int'(fifo_level), 4);
        chk("pp.overflow", int'(overflow),   0);
        chk("pp.head",     int'(out_data),   20);
        // Drop together with ovf_clear: the drop wins
        step(1'b1, 60, 1'b0, 1'b0, "dropclr");
        step(1'b1, 60, 1'b0, 1'b1, "dropclr");
        chk("dropclr.overflow", int'(overflow), 1);
        exp_list = '{20, 30, 40, 50};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp.order[%0d]", i), int'(out_data), exp_list[i]);
            step(1'b0, 0, 1'b1, 1'b0, "pp_drain");
        end
        step(1'b0, 0, 1'b0, 1'b1, "pp_clr");

        // Reset mid-block with data queued
        step(1'b1, 7, 1'b0, 1'b0, "rst");
        step(1'b1, 9, 1'b0, 1'b0, "rst");
        step(1'b1, 5, 1'b0, 1'b0, "rst");
        chk("rst.pre_level", int'(fifo_level), 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst.async_level", int'(fifo_level), 0);
        chk("rst.async_valid", int'(out_valid),  0);
        chk("rst.async_data",  int'(out_data),   0);
        @(posedge clk);
        #1;
        check_model("rst_hold");
        reset = 1'b0;
        step(1'b1, 8, 1'b0, 1'b0, "rst_after");
        step(1'b1, 8, 1'b0, 1'b0, "rst_after");
        chk("rst.first_result", int'(out_data), 8);
        step(1'b0, 0, 1'b1, 1'b0, "rst_after");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit r;
            bit c;
            int d;
            v = ($urandom_range(0, 3) != 0);
            r = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 15) == 0);
            d = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 65535));
            step(v, d, r, c, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
